// File: rtl/pick_dir_encoder_if.sv
// Keycode-in / dir-out bundle between the keycode PIO side and the pick motion block.
interface pick_dir_encoder_if;
  logic       enable;
  logic [7:0] keycode;
  logic [2:0] dir;
  logic       dir_upd;

  modport master (
    output enable,
    output keycode,
    input  dir,
    input  dir_upd
  );

  modport slave (
    input  enable,
    input  keycode,
    output dir,
    output dir_upd
  );
endinterface

// File: rtl/pick_dir_encoder.sv
// Per-frame keycode decoder with a hold-to-accelerate FSM driving the pick dir code.
// Optional: define PICK_DECEL_EN for a one-frame slow step when a fast hold is released.
module pick_dir_encoder #(
  parameter int         HOLD_FRAMES = 30,
  parameter int         CNT_W       = 6,
  parameter logic [7:0] KEY_UP      = 8'h1A,
  parameter logic [7:0] KEY_DOWN    = 8'h16
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  pick_dir_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    SLOW_UP = 3'b001,
    SLOW_DN = 3'b010,
    FAST_DN = 3'b011,
    FAST_UP = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    K_NONE,
    K_UP,
    K_DN
  } key_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HOLD_FRAMES);

  logic   ff1;
  logic   ff2;
  logic   prev;
  logic   tick;
  key_t   key;
  state_t state_q;
  state_t state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0] dir_q;
  logic [2:0] dir_d;
  logic       upd_q;

  // frame_clk is asynchronous: two-flop sync, then rising-edge detect
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ff1  <= 1'b0;
      ff2  <= 1'b0;
      prev <= 1'b0;
    end else begin
      ff1  <= frame_clk;
      ff2  <= ff1;
      prev <= ff2;
    end
  end

  assign tick = ff2 & ~prev;

  always_comb begin
    key = K_NONE;
    unique case (1'b1)
      (bus.keycode == KEY_UP):   key = K_UP;
      (bus.keycode == KEY_DOWN): key = K_DN;
      default:                   key = K_NONE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (!bus.enable) begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (key == K_UP) begin
              state_d = SLOW_UP;
              cnt_d   = CNT_ONE;
            end else if (key == K_DN) begin
              state_d = SLOW_DN;
              cnt_d   = CNT_ONE;
            end
          end
          SLOW_UP: begin
            if (key == K_UP) begin
              if (cnt_q == CNT_LAST) begin
                state_d = FAST_UP;
                cnt_d   = CNT_FULL;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end else if (key == K_DN) begin
              state_d = SLOW_DN;
              cnt_d   = CNT_ONE;
            end else begin
              state_d = IDLE;
              cnt_d   = CNT_ZERO;
            end
          end
          SLOW_DN: begin
            if (key == K_DN) begin
              if (cnt_q == CNT_LAST) begin
                state_d = FAST_DN;
                cnt_d   = CNT_FULL;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end else if (key == K_UP) begin
              state_d = SLOW_UP;
              cnt_d   = CNT_ONE;
            end else begin
              state_d = IDLE;
              cnt_d   = CNT_ZERO;
            end
          end
          FAST_UP: begin
            if (key == K_DN) begin
              state_d = SLOW_DN;
              cnt_d   = CNT_ONE;
            end else if (key == K_NONE) begin
`ifdef PICK_DECEL_EN
              state_d = SLOW_UP;
`else
              state_d = IDLE;
`endif
              cnt_d   = CNT_ZERO;
            end
          end
          FAST_DN: begin
            if (key == K_UP) begin
              state_d = SLOW_UP;
              cnt_d   = CNT_ONE;
            end else if (key == K_NONE) begin
`ifdef PICK_DECEL_EN
              state_d = SLOW_DN;
`else
              state_d = IDLE;
`endif
              cnt_d   = CNT_ZERO;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        endcase
      end
    end
  end

  always_comb begin
    dir_d = 3'b000;
    unique case (state_d)
      SLOW_UP: dir_d = 3'b001;
      SLOW_DN: dir_d = 3'b010;
      FAST_DN: dir_d = 3'b011;
      FAST_UP: dir_d = 3'b100;
      default: dir_d = 3'b000;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dir_q <= 3'b000;
      upd_q <= 1'b0;
    end else begin
      upd_q <= tick;
      if (tick) begin
        dir_q <= dir_d;
      end
    end
  end

  assign bus.dir     = dir_q;
  assign bus.dir_upd = upd_q;

endmodule

// File: tb/tb_pick_dir_encoder.sv
// Directed bench for pick_dir_encoder with HOLD_FRAMES=4.
// Honors PICK_DECEL_EN for the fast-release expectation.
module tb_pick_dir_encoder;

  logic Clk       = 1'b0;
  logic Reset_n   = 1'b0;
  logic frame_clk = 1'b0;
  int   n_tests   = 0;
  int   n_fail    = 0;

  pick_dir_encoder_if bus ();

  pick_dir_encoder #(
    .HOLD_FRAMES(4),
    .CNT_W(6),
    .KEY_UP(8'h1A),
    .KEY_DOWN(8'h16)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_clk(frame_clk),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wait up to 8 edges for dir_upd; returns edge count, 0 on timeout
  task automatic wait_upd(output int lat);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk);
      #1;
      if (bus.dir_upd === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic frame(input logic [7:0] kc, input logic en,
                       input logic [2:0] exp, input string tag);
    int lat;
    @(negedge Clk);
    bus.keycode = kc;
    bus.enable  = en;
    frame_clk   = 1'b1;
    wait_upd(lat);
    chk({tag, "_lat"}, 8'(lat), 8'd3);
    chk(tag, {5'd0, bus.dir}, {5'd0, exp});
    @(posedge Clk);
    #1;
    chk({tag, "_pulse"}, {7'd0, bus.dir_upd}, 8'd0);
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bus.keycode = 8'h00;
    bus.enable  = 1'b1;

    // reset with frame_clk toggling
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      frame_clk = ~frame_clk;
      @(posedge Clk);
      #1;
      chk("rst_dir", {5'd0, bus.dir}, 8'd0);
      chk("rst_upd", {7'd0, bus.dir_upd}, 8'd0);
    end
    @(negedge Clk);
    frame_clk = 1'b0;
    Reset_n   = 1'b1;
    repeat (4) @(negedge Clk);
    chk("idle_upd", {7'd0, bus.dir_upd}, 8'd0);
    chk("idle_dir", {5'd0, bus.dir}, 8'd0);

    // hold up: slow for 3 frames then fast
    frame(8'h1A, 1'b1, 3'b001, "up1");
    frame(8'h1A, 1'b1, 3'b001, "up2");
    frame(8'h1A, 1'b1, 3'b001, "up3");
    frame(8'h1A, 1'b1, 3'b100, "up4");
    frame(8'h1A, 1'b1, 3'b100, "up5");
    frame(8'h00, 1'b1, 3'b000, "up_rel");

    // hold down then reverse from fast
    frame(8'h16, 1'b1, 3'b010, "dn1");
    frame(8'h16, 1'b1, 3'b010, "dn2");
    frame(8'h16, 1'b1, 3'b010, "dn3");
    frame(8'h16, 1'b1, 3'b011, "dn4");
    frame(8'h1A, 1'b1, 3'b001, "rev_up");

    // continue up to fast, then release
    frame(8'h1A, 1'b1, 3'b001, "ru2");
    frame(8'h1A, 1'b1, 3'b001, "ru3");
    frame(8'h1A, 1'b1, 3'b100, "ru4");
`ifdef PICK_DECEL_EN
    frame(8'h00, 1'b1, 3'b001, "decel");
    frame(8'h00, 1'b1, 3'b000, "decel_idle");
`else
    frame(8'h00, 1'b1, 3'b000, "fast_rel");
    frame(8'h00, 1'b1, 3'b000, "fast_rel2");
`endif

    // fast down, pause, resume restarts the hold
    frame(8'h16, 1'b1, 3'b010, "p1");
    frame(8'h16, 1'b1, 3'b010, "p2");
    frame(8'h16, 1'b1, 3'b010, "p3");
    frame(8'h16, 1'b1, 3'b011, "p4");
    frame(8'h16, 1'b0, 3'b000, "pause");
    frame(8'h16, 1'b1, 3'b010, "resume");
    frame(8'h16, 1'b1, 3'b010, "resume2");

    // unrelated key and a pulse between frames
    frame(8'h04, 1'b1, 3'b000, "other_key");
    @(negedge Clk);
    bus.keycode = 8'h1A;
    repeat (2) @(negedge Clk);
    bus.keycode = 8'h00;
    chk("gap_dir", {5'd0, bus.dir}, 8'd0);
    frame(8'h00, 1'b1, 3'b000, "gap_frame");

    // build a hold, then reset with frame_clk high
    frame(8'h1A, 1'b1, 3'b001, "h1");
    frame(8'h1A, 1'b1, 3'b001, "h2");
    @(negedge Clk);
    Reset_n   = 1'b0;
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst2_dir", {5'd0, bus.dir}, 8'd0);
    Reset_n = 1'b1;
    wait_upd(lat);
    chk("rel_lat", 8'(lat), 8'd3);
    chk("rel_dir", {5'd0, bus.dir}, 8'd1);
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    frame(8'h1A, 1'b1, 3'b001, "h_new2");
    frame(8'h1A, 1'b1, 3'b001, "h_new3");
    frame(8'h1A, 1'b1, 3'b100, "h_new4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
